rs485_tx_fifo: RTL

Byte-wide transmit FIFO and UART pacing stage between the BRAM dump reader (or main controller) and `rs485_top`. It accepts bytes on a valid/ready interface, buffers up to 2^DEPTH_LOG2 of them, and hands them one at a time to the RS485 transmitter. Each hand-off is a single-cycle `tx_cmd` pulse gated by the transmitter's idle flag `tx_ready`. The stage decouples the producer's burst rate from the 115200-baud line and reports overflow and transmitter-stall errors.

---
 rtl/rs485_tx_fifo.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/rs485_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// rs485_tx_fifo : byte FIFO + tx_cmd pacing in front of rs485_top.
// Optional inter-byte gap: define RS485_TXFIFO_GAP_EN.          Rev 1.0
// ============================================================================
module rs485_tx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 15,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                flush,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                tx_ready,
  output logic                tx_cmd,
  output logic [7:0]          tx_data,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic                tx_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [TMO_W-1:0]      TMO_MAX  = TMO_W'(BUSY_TIMEOUT);
  localparam logic [TMO_W-1:0]      TMO_ONE  = TMO_W'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND      = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_IDLE = 3'd3;
`ifdef RS485_TXFIFO_GAP_EN
  localparam logic [2:0] S_GAP       = 3'd4;
  localparam int                GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
`endif

  generate
    if (DEPTH_LOG2 < 1 || BUSY_TIMEOUT < 1 || GAP_CYCLES < 1) begin : g_param_err
      $error("rs485_tx_fifo: DEPTH_LOG2, BUSY_TIMEOUT and GAP_CYCLES must be >= 1");
    end
  endgenerate

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [2:0]            state_q, state_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  overflow_q, overflow_d;
  logic                  tx_err_q, tx_err_d;
`ifdef RS485_TXFIFO_GAP_EN
  logic [GAP_W-1:0]      gap_q, gap_d;
`endif

  logic w_full, w_push, w_pop, w_timeout;

  assign w_full   = (count_q == CNT_FULL);
  assign w_push   = in_valid && !w_full && !flush;

  assign in_ready = !w_full;
  assign tx_cmd   = (state_q == S_SEND);
  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_err   = tx_err_q;

  // Pacing FSM; a pop is suppressed during flush so a cleared byte is never sent.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    w_pop     = 1'b0;
    w_timeout = 1'b0;
`ifdef RS485_TXFIFO_GAP_EN
    gap_d     = gap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && tx_ready && !flush) begin
          w_pop   = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tmo_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_ready) begin
          state_d = S_WAIT_IDLE;
        end else if (tmo_q == TMO_MAX) begin
          w_timeout = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_WAIT_IDLE: begin
        if (tx_ready) begin
`ifdef RS485_TXFIFO_GAP_EN
          gap_d   = '0;
          state_d = S_GAP;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef RS485_TXFIFO_GAP_EN
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q;
    tx_err_d   = tx_err_q;
    if (w_pop) begin
      tx_data_d = mem_q[rd_q];
    end
    if (flush) begin
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      tx_err_d   = 1'b0;
    end else begin
      if (w_push) begin
        wr_d = wr_q + PTR_ONE;
      end
      if (w_pop) begin
        rd_d = rd_q + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        count_d = count_q + CNT_ONE;
      end else if (w_pop && !w_push) begin
        count_d = count_q - CNT_ONE;
      end
      // Judged on occupancy at the start of the cycle: a same-cycle pop does not rescue it.
      if (in_valid && w_full) begin
        overflow_d = 1'b1;
      end
      if (w_timeout) begin
        tx_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      tx_err_q   <= tx_err_d;
    end
  end

`ifdef RS485_TXFIFO_GAP_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  // Storage needs no reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_q] <= in_data;
    end
  end

endmodule
`default_nettype wire
